ps2_kbd_rx: RTL

PS/2 keyboard receiver feeding the MIO bus PS/2 read port (0xFFFFDxxx). It does four things:
- Synchronises and de-glitches the keyboard clock and data lines.
- Deserialises 11-bit device-to-host frames and checks parity and the stop bit.
- Queues good scan codes in a small FIFO.
- Presents the FIFO head as `ps2_key` and `ps2_ready`; the bus returns these to the CPU as `{ps2_ready, 23'h0, ps2_key}`. A bus read strobe pops the head.

---
 rtl/ps2_pkg.sv | 19 +
 rtl/ps2_fifo.sv | 79 +++++++
 rtl/ps2_kbd_rx.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/ps2_pkg.sv
// Shared types and helpers for the PS/2 keyboard receiver.
package ps2_pkg;

  localparam int unsigned PS2_DATA_BITS = 8;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } ps2_state_e;

  // True when data plus parity hold an odd number of ones.
  function automatic logic odd_parity_ok(input logic [PS2_DATA_BITS-1:0] data,
                                         input logic                     par);
    return ^{data, par};
  endfunction

endpackage

// File: rtl/ps2_fifo.sv
// Count-based synchronous FIFO; head word and flags are registered.
module ps2_fifo #(
  parameter int unsigned FIFO_AW = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic       pop,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       empty,
  output logic       full
);

  localparam int unsigned DEPTH = 1 << FIFO_AW;
  localparam int unsigned CW    = FIFO_AW + 1;

  logic [7:0]         mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr;
  logic [FIFO_AW-1:0] rd_ptr;
  logic [FIFO_AW-1:0] rd_nxt_c;
  logic [CW-1:0]      count;
  logic [CW-1:0]      count_nxt_c;
  logic [7:0]         head_nxt_c;
  logic               push_ok_c;
  logic               pop_ok_c;

  // A pop on an empty FIFO is ignored; a push when full only fits if a pop frees a slot.
  assign pop_ok_c  = pop && !empty;
  assign push_ok_c = push && (!full || pop_ok_c);
  assign rd_nxt_c  = rd_ptr + FIFO_AW'(pop_ok_c);

  // Next occupancy and the word that will sit at the head next cycle.
  always_comb begin
    count_nxt_c = count;
    head_nxt_c  = 8'h00;
    if (push_ok_c && !pop_ok_c) begin
      count_nxt_c = count + CW'(1);
    end else if (pop_ok_c && !push_ok_c) begin
      count_nxt_c = count - CW'(1);
    end
    if (count_nxt_c == '0) begin
      head_nxt_c = 8'h00;
    end else if (push_ok_c && (rd_nxt_c == wr_ptr)) begin
      head_nxt_c = din;
    end else begin
      head_nxt_c = mem[rd_nxt_c];
    end
  end

  // Pointers, occupancy, flags and registered head.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      dout   <= 8'h00;
      empty  <= 1'b1;
      full   <= 1'b0;
    end else begin
      if (push_ok_c) begin
        wr_ptr <= wr_ptr + FIFO_AW'(1);
      end
      rd_ptr <= rd_nxt_c;
      count  <= count_nxt_c;
      dout   <= head_nxt_c;
      empty  <= (count_nxt_c == '0);
      full   <= (count_nxt_c == CW'(DEPTH));
    end
  end

  // Storage array; contents need no reset.
  always_ff @(posedge clk) begin
    if (push_ok_c) begin
      mem[wr_ptr] <= din;
    end
  end

endmodule

// File: rtl/ps2_kbd_rx.sv
// PS/2 keyboard receiver: line conditioning, frame decode and scan-code FIFO.
module ps2_kbd_rx #(
  parameter int unsigned FIFO_AW    = 3,
  parameter int unsigned FILTER_LEN = 4,
  parameter int unsigned TIMEOUT    = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  input  logic       rd_ack,
  output logic [7:0] ps2_key,
  output logic       ps2_ready,
  output logic       overflow,
  output logic       frame_err
);
  import ps2_pkg::*;

  localparam int unsigned FW  = $clog2(FILTER_LEN + 1);
  localparam int unsigned TW  = $clog2(TIMEOUT + 1);
  localparam int unsigned BCW = $clog2(PS2_DATA_BITS);

  // Lane 0 is the keyboard clock, lane 1 the keyboard data.
  logic [1:0]               raw_c;
  logic [1:0]               meta;
  logic [1:0]               sync;
  logic [1:0]               filt;
  logic [FW-1:0]            fcnt [2];
  logic                     clk_filt_d;
  logic                     fall_c;

  ps2_state_e               state;
  logic [BCW-1:0]           bit_cnt;
  logic [PS2_DATA_BITS-1:0] shreg;
  logic                     par_bit;
  logic [TW-1:0]            tcnt;
  logic                     frame_good_c;
  logic                     push_c;

  logic                     fifo_empty;
  logic                     fifo_full;

  assign raw_c = {ps2_data, ps2_clk};

  // Two-flop synchroniser followed by a hold-for-FILTER_LEN-cycles filter per line.
  always_ff @(posedge clk) begin
    if (!rst) begin
      meta       <= 2'b11;
      sync       <= 2'b11;
      filt       <= 2'b11;
      fcnt[0]    <= '0;
      fcnt[1]    <= '0;
      clk_filt_d <= 1'b1;
    end else begin
      meta       <= raw_c;
      sync       <= meta;
      clk_filt_d <= filt[0];
      for (int i = 0; i < 2; i++) begin
        if (sync[i] == filt[i]) begin
          fcnt[i] <= '0;
        end else if (fcnt[i] == FW'(FILTER_LEN - 1)) begin
          filt[i] <= sync[i];
          fcnt[i] <= '0;
        end else begin
          fcnt[i] <= fcnt[i] + FW'(1);
        end
      end
    end
  end

  assign fall_c       = clk_filt_d & ~filt[0];
  assign frame_good_c = filt[1] && odd_parity_ok(shreg, par_bit);
  assign push_c       = fall_c && (state == STOP) && frame_good_c;

  // Frame decoder clocked by filtered falling edges, with a mid-frame watchdog.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      shreg     <= '0;
      par_bit   <= 1'b0;
      tcnt      <= '0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      if ((state != IDLE) && !fall_c && (tcnt == TW'(TIMEOUT - 1))) begin
        state     <= IDLE;
        bit_cnt   <= '0;
        shreg     <= '0;
        tcnt      <= '0;
        frame_err <= 1'b1;
      end else begin
        if ((state == IDLE) || fall_c) begin
          tcnt <= '0;
        end else begin
          tcnt <= tcnt + TW'(1);
        end
        if (fall_c) begin
          case (state)
            IDLE: begin
              if (!filt[1]) begin
                state   <= DATA;
                bit_cnt <= '0;
              end
            end
            DATA: begin
              shreg   <= {filt[1], shreg[PS2_DATA_BITS-1:1]};
              bit_cnt <= bit_cnt + BCW'(1);
              if (bit_cnt == BCW'(PS2_DATA_BITS - 1)) begin
                state <= PARITY;
              end
            end
            PARITY: begin
              par_bit <= filt[1];
              state   <= STOP;
            end
            STOP: begin
              frame_err <= !frame_good_c;
              state     <= IDLE;
            end
            default: state <= IDLE;
          endcase
        end
      end
    end
  end

  // Sticky overflow: set on a dropped byte, cleared by the next accepted pop.
  always_ff @(posedge clk) begin
    if (!rst) begin
      overflow <= 1'b0;
    end else if (push_c && fifo_full && !rd_ack) begin
      overflow <= 1'b1;
    end else if (rd_ack && !fifo_empty) begin
      overflow <= 1'b0;
    end
  end

  ps2_fifo #(
    .FIFO_AW(FIFO_AW)
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (push_c),
    .pop  (rd_ack),
    .din  (shreg),
    .dout (ps2_key),
    .empty(fifo_empty),
    .full (fifo_full)
  );

  assign ps2_ready = ~fifo_empty;

endmodule
